// File: rtl/noc_switch_traversal_pkg.sv
// Shared port encoding and XY routing helpers
// for the 5-port mesh router.
package noc_pkg;

   localparam int P_N = 4;
   localparam int P_S = 3;
   localparam int P_E = 2;
   localparam int P_W = 1;
   localparam int P_L = 0;
   localparam int NPORT = 5;

   typedef logic [4:0] port_oh_t;

   function automatic port_oh_t xy_route(
      input int dx,
      input int dy,
      input int my_x,
      input int my_y
   );
      port_oh_t r;
      r = '0;
      if (dx > my_x) r[P_E] = 1'b1;
      else if (dx < my_x) r[P_W] = 1'b1;
      else if (dy > my_y) r[P_S] = 1'b1;
      else if (dy < my_y) r[P_N] = 1'b1;
      else r[P_L] = 1'b1;
      return r;
   endfunction

   function automatic logic is_onehot(input port_oh_t v);
      int n;
      n = 0;
      for (int k = 0; k < NPORT; k++) n += int'(v[k]);
      return n == 1;
   endfunction

endpackage

// File: rtl/noc_switch_traversal_if.sv
// Input-buffer, arbiter-turn, credit and output-link
// signals of the switch traversal stage.
interface noc_switch_traversal_if #(
   parameter int DATA_W = 32
);
   logic [4:0]          in_valid_i;
   logic [5*DATA_W-1:0] in_flit_i;
   logic [4:0]          in_pop_o;
   logic [4:0]          N_turn_i;
   logic [4:0]          S_turn_i;
   logic [4:0]          E_turn_i;
   logic [4:0]          W_turn_i;
   logic [4:0]          L_turn_i;
   logic [4:0]          credit_ret_i;
   logic [4:0]          out_valid_o;
   logic [5*DATA_W-1:0] out_flit_o;
   logic [4:0]          err_uturn_o;

   modport slave (
      input  in_valid_i, in_flit_i,
      input  N_turn_i, S_turn_i, E_turn_i, W_turn_i, L_turn_i,
      input  credit_ret_i,
      output in_pop_o, out_valid_o, out_flit_o, err_uturn_o
   );

   modport master (
      output in_valid_i, in_flit_i,
      output N_turn_i, S_turn_i, E_turn_i, W_turn_i, L_turn_i,
      output credit_ret_i,
      input  in_pop_o, out_valid_o, out_flit_o, err_uturn_o
   );
endinterface

// File: rtl/noc_switch_traversal_credit.sv
// Per-output downstream credit counter; saturates at
// the downstream buffer depth.
module noc_credit_counter #(
   parameter int CREDITS = 4,
   localparam int CW = $clog2(CREDITS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          consume_i,
   input  logic          ret_i,
   output logic          has_credit_o,
   output logic [CW-1:0] count_o
);

   localparam logic [CW-1:0] FULL = CW'(CREDITS);

   logic [CW-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (consume_i && !ret_i)
         cnt_d = cnt_q - 1'b1;
      else if (ret_i && !consume_i && cnt_q != FULL)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= FULL;
      else     cnt_q <= cnt_d;
   end

   assign has_credit_o = cnt_q != '0;
   assign count_o      = cnt_q;

   // A return with no free slot downstream means a protocol bug there.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(ret_i && !consume_i && cnt_q == FULL));

endmodule

// File: rtl/noc_switch_traversal.sv
// Switch traversal: XY route, turn/credit grant, pop
// and register each granted head flit onto its link.
module noc_switch_traversal
   import noc_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int COORD_W = 2,
   parameter int MY_X    = 1,
   parameter int MY_Y    = 1,
   parameter int CREDITS = 4
) (
   input logic                    clk,
   input logic                    rst,
   noc_switch_traversal_if.slave  bus
);

   localparam int CW = $clog2(CREDITS + 1);

   port_oh_t turn  [NPORT];
   port_oh_t route [NPORT];

   logic [4:0]             uturn;
   logic [4:0]             pop;
   logic [4:0]             has_credit;
   logic [4:0]             consume;
   logic [4:0][4:0]        grant;
   logic [4:0]             out_valid_d, out_valid_q;
   logic [4:0]             err_d, err_q;
   logic [4:0][DATA_W-1:0] flit_d, flit_q;
   logic [CW-1:0]          credit_cnt [NPORT];

   assign turn[P_N] = bus.N_turn_i;
   assign turn[P_S] = bus.S_turn_i;
   assign turn[P_E] = bus.E_turn_i;
   assign turn[P_W] = bus.W_turn_i;
   assign turn[P_L] = bus.L_turn_i;

   always_comb begin
      for (int i = 0; i < NPORT; i++) begin
         route[i] = xy_route(
            int'(bus.in_flit_i[i*DATA_W + DATA_W - 1 -: COORD_W]),
            int'(bus.in_flit_i[i*DATA_W + DATA_W - 1 - COORD_W -: COORD_W]),
            MY_X, MY_Y);
         uturn[i] = bus.in_valid_i[i] && route[i][i];
      end
   end

   always_comb begin
      grant   = '0;
      consume = '0;
      flit_d  = flit_q;
      for (int o = 0; o < NPORT; o++) begin
         for (int i = 0; i < NPORT; i++) begin
            grant[o][i] = is_onehot(turn[o]) && turn[o][i]
                       && bus.in_valid_i[i] && route[i][o]
                       && (o != i) && has_credit[o];
            if (grant[o][i])
               flit_d[o] = bus.in_flit_i[i*DATA_W +: DATA_W];
         end
         consume[o] = |grant[o];
      end
   end

   always_comb begin
      pop = uturn;
      for (int o = 0; o < NPORT; o++) pop |= grant[o];
      out_valid_d = consume;
      err_d       = uturn;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= '0;
         err_q       <= '0;
         flit_q      <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         flit_q      <= flit_d;
      end
   end

   for (genvar o = 0; o < NPORT; o++) begin : g_cc
      noc_credit_counter #(.CREDITS(CREDITS)) u_cc (
         .clk          (clk),
         .rst          (rst),
         .consume_i    (consume[o]),
         .ret_i        (bus.credit_ret_i[o]),
         .has_credit_o (has_credit[o]),
         .count_o      (credit_cnt[o])
      );
   end

   assign bus.in_pop_o    = rst ? '0 : pop;
   assign bus.out_valid_o = out_valid_q;
   assign bus.out_flit_o  = flit_q;
   assign bus.err_uturn_o = err_q;

endmodule

// File: tb/tb_noc_switch_traversal.sv
// Directed bench: stimulus pushes expected link outputs into a
// queue, a negedge monitor pops and compares them.
module tb_noc_switch_traversal;

   typedef struct packed {
      logic [4:0]       ov;
      logic [4:0]       err;
      logic [4:0][31:0] f;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [4:0] turn [5];

   int vectors = 0;
   int miscompares = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   noc_switch_traversal_if #(.DATA_W(32)) bus ();

   assign bus.N_turn_i = turn[4];
   assign bus.S_turn_i = turn[3];
   assign bus.E_turn_i = turn[2];
   assign bus.W_turn_i = turn[1];
   assign bus.L_turn_i = turn[0];

   noc_switch_traversal #(
      .DATA_W(32), .COORD_W(2), .MY_X(1), .MY_Y(1), .CREDITS(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic int sel_idx(input logic [4:0] v);
      int r;
      r = 0;
      for (int k = 0; k < 5; k++) if (v[k]) r = k;
      return r;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (bus.out_valid_o != 5'b0 || bus.err_uturn_o != 5'b0) begin
         vectors++;
         if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_out: valid=%b err=%b with nothing expected",
                     bus.out_valid_o, bus.err_uturn_o);
         end else begin
            e = q.pop_front();
            if (bus.out_valid_o !== e.ov || bus.err_uturn_o !== e.err) begin
               miscompares++;
               $display("FAIL out_vec: valid=%b err=%b want valid=%b err=%b",
                        bus.out_valid_o, bus.err_uturn_o, e.ov, e.err);
            end
            for (int o = 0; o < 5; o++) begin
               if (e.ov[o]) begin
                  vectors++;
                  if (bus.out_flit_o[o*32 +: 32] !== e.f[o]) begin
                     miscompares++;
                     $display("FAIL out_flit[%0d]: got %h want %h",
                              o, bus.out_flit_o[o*32 +: 32], e.f[o]);
                  end
               end
            end
         end
      end
   end

   task automatic idle();
      bus.in_valid_i   = '0;
      bus.credit_ret_i = '0;
      for (int k = 0; k < 5; k++) turn[k] = '0;
   endtask

   task automatic set_in(input int i, input logic [31:0] f);
      bus.in_valid_i[i]        = 1'b1;
      bus.in_flit_i[i*32 +: 32] = f;
   endtask

   task automatic step(input logic [4:0] ep, input logic [4:0] eov,
                       input logic [4:0] eerr);
      exp_t e;
      #1;
      vectors++;
      if (bus.in_pop_o !== ep) begin
         miscompares++;
         $display("FAIL in_pop: got %b want %b", bus.in_pop_o, ep);
      end
      if ((eov | eerr) != 5'b0) begin
         e.ov  = eov;
         e.err = eerr;
         e.f   = '0;
         for (int o = 0; o < 5; o++)
            if (eov[o]) e.f[o] = bus.in_flit_i[sel_idx(turn[o])*32 +: 32];
         q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic chk_cr(input int o, input int want);
      vectors++;
      if (int'(dut.credit_cnt[o]) != want) begin
         miscompares++;
         $display("FAIL credit[%0d]: got %0d want %0d",
                  o, dut.credit_cnt[o], want);
      end
   endtask

   task automatic chk_out_idle(input string tag);
      vectors++;
      if (bus.out_valid_o !== 5'b0 || bus.err_uturn_o !== 5'b0) begin
         miscompares++;
         $display("FAIL %s: valid=%b err=%b want 0",
                  tag, bus.out_valid_o, bus.err_uturn_o);
      end
   endtask

   initial begin
      bus.in_flit_i = '0;
      idle();
      @(negedge clk);
      // pops must stay low while in reset
      set_in(3, 32'h8000_00AB);
      turn[2] = 5'b01000;
      step(5'b00000, 5'b0, 5'b0);
      idle();
      rst = 1'b0;
      chk_out_idle("reset_out");
      for (int o = 0; o < 5; o++) chk_cr(o, 4);
      step(5'b00000, 5'b0, 5'b0);

      // basic grant S -> E
      set_in(3, 32'h8000_00AB);
      turn[2] = 5'b01000;
      step(5'b01000, 5'b00100, 5'b0);
      chk_cr(2, 3);
      idle();
      step(5'b0, 5'b0, 5'b0);

      // turn mismatch holds the head
      set_in(3, 32'h8000_00CD);
      turn[2] = 5'b00001;
      repeat (3) step(5'b0, 5'b0, 5'b0);
      turn[2] = 5'b01000;
      step(5'b01000, 5'b00100, 5'b0);
      chk_cr(2, 2);
      idle();
      bus.credit_ret_i = 5'b00100;
      step(5'b0, 5'b0, 5'b0);
      step(5'b0, 5'b0, 5'b0);
      bus.credit_ret_i = '0;
      chk_cr(2, 4);

      // credit exhaustion
      turn[2] = 5'b01000;
      for (int k = 1; k <= 4; k++) begin
         set_in(3, 32'h8000_0000 | 32'(k));
         step(5'b01000, 5'b00100, 5'b0);
      end
      set_in(3, 32'h8000_0005);
      step(5'b0, 5'b0, 5'b0);
      chk_cr(2, 0);
      bus.credit_ret_i = 5'b00100;
      step(5'b0, 5'b0, 5'b0);
      bus.credit_ret_i = '0;
      step(5'b01000, 5'b00100, 5'b0);
      chk_cr(2, 0);
      bus.in_valid_i   = '0;
      bus.credit_ret_i = 5'b00100;
      step(5'b0, 5'b0, 5'b0);
      chk_cr(2, 1);
      set_in(3, 32'h8000_0006);
      step(5'b01000, 5'b00100, 5'b0);
      chk_cr(2, 1);
      idle();
      bus.credit_ret_i = 5'b00100;
      repeat (3) step(5'b0, 5'b0, 5'b0);
      bus.credit_ret_i = '0;
      chk_cr(2, 4);

      // parallel outputs: N -> S and W -> E
      set_in(4, 32'h6000_0011);
      set_in(1, 32'hD000_0022);
      turn[3] = 5'b10000;
      turn[2] = 5'b00010;
      step(5'b10010, 5'b01100, 5'b0);
      chk_cr(3, 3);
      chk_cr(2, 3);
      idle();
      bus.credit_ret_i = 5'b01100;
      step(5'b0, 5'b0, 5'b0);
      bus.credit_ret_i = '0;
      chk_cr(3, 4);
      chk_cr(2, 4);

      // U-turns, E -> E and L -> L
      set_in(2, 32'h9000_0033);
      step(5'b00100, 5'b0, 5'b00100);
      idle();
      set_in(0, 32'h5000_0044);
      step(5'b00001, 5'b0, 5'b00001);
      idle();
      chk_cr(2, 4);

      // non-one-hot and zero turn vectors
      set_in(3, 32'h8000_0007);
      set_in(1, 32'h8000_0008);
      turn[2] = 5'b01010;
      step(5'b0, 5'b0, 5'b0);
      turn[2] = 5'b00000;
      step(5'b0, 5'b0, 5'b0);
      idle();

      // reset right after a grant
      set_in(3, 32'h8000_0009);
      turn[2] = 5'b01000;
      step(5'b01000, 5'b00100, 5'b0);
      rst = 1'b1;
      step(5'b0, 5'b0, 5'b0);
      chk_out_idle("reset_mid");
      chk_cr(2, 4);
      rst = 1'b0;
      idle();
      repeat (3) step(5'b0, 5'b0, 5'b0);

      while (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         vectors++;
         miscompares++;
         $display("FAIL missing_out: valid=none want valid=%b err=%b",
                  e.ov, e.err);
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/noc_switch_traversal.md
Name: noc_switch_traversal

Overview:
Switch-traversal stage of the 5-port mesh router (N,S,E,W,L). Consumes the per-output one-hot turn vectors from the router's rotating arbiter, XY-routes the head flit of each input buffer, and grants at most one input per output when that input holds the turn and downstream credit is available. Each granted flit is popped from its input buffer and registered onto the output link.

Parameters:
DATA_W, 32, flit width in bits
COORD_W, 2, width of each destination coordinate field
MY_X, 1, this router's X coordinate
MY_Y, 1, this router's Y coordinate
CREDITS, 4, downstream buffer depth per output (initial credit count)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid_i  in  5  input buffer head valid, bit order N=4,S=3,E=2,W=1,L=0
in_flit_i  in  5*DATA_W  head flits, slice k = in_flit_i[k*DATA_W +: DATA_W]
in_pop_o  out  5  pop strobe to input buffers (combinational)
N_turn_i, S_turn_i, E_turn_i, W_turn_i, L_turn_i  in  5 each  one-hot input selection per output, from arbiter
credit_ret_i  in  5  per-output credit return pulse from downstream
out_valid_o  out  5  per-output flit valid (registered, 1-cycle pulse per flit)
out_flit_o  out  5*DATA_W  per-output flit (registered)
err_uturn_o  out  5  per-input pulse: head flit dropped as U-turn (registered)

Behaviour:
- Flit dest fields: dx = flit[DATA_W-1 -: COORD_W], dy = next COORD_W bits below dx.
- XY route per input:
  - dx>MY_X → E; dx<MY_X → W.
  - Else dy>MY_Y → S; dy<MY_Y → N.
  - Else L.
- U-turn: route equals the arrival port (including L→L).
  - Head is dropped: in_pop_o[i]=1 in the same cycle; err_uturn_o[i]=1 next cycle.
  - No output, no credit consumed. Drop happens regardless of turn or credits.
- Grant for output o to input i, all required:
  - turn_o is exactly one-hot with bit i set.
  - in_valid_i[i]=1.
  - route(i)==o and i≠o.
  - credit[o]>0.
- A zero or non-one-hot turn vector gives no grant for that output that cycle. No error is flagged.
- Each input routes to one output, so an input is popped at most once per cycle. in_pop_o[i] = grant or U-turn drop, combinational, same cycle.
- Latency: grant in cycle t gives out_valid_o[o]=1 and out_flit_o[o]=granted flit in cycle t+1. Flits from different outputs proceed in parallel.
- out_valid_o is a 1-cycle pulse per flit; back-pressure is by credits only. out_flit_o holds its last value when valid is low.
- Credit counter per output, width clog2(CREDITS+1):
  - Reset to CREDITS.
  - Grant only: −1. Credit return only: +1. Both in the same cycle: unchanged.
  - Return while at CREDITS: saturate, ignore (simulation assertion fires).
  - No grant at 0.
- Reset (also mid-operation): out_valid_o=0, out_flit_o=0, err_uturn_o=0, credits=CREDITS.
  - A flit registered in the cycle before rst is discarded.
  - in_pop_o is forced to 0 while rst=1.
- A non-popped head is held by the input buffer and re-evaluated every cycle. Starvation freedom comes from turn rotation.

Decomposition:
- noc_pkg:
  - Port index constants P_N=4, P_S=3, P_E=2, P_W=1, P_L=0.
  - typedef port_oh_t (logic [4:0]).
  - Function xy_route(dx,dy,my_x,my_y) returning port_oh_t.
  - Function is_onehot.
- Sub-module noc_credit_counter: one per output, with inputs consume and ret, outputs has_credit and count.

Test Plan:
- Reset: hold rst 2 cycles, then release → out_valid_o=0, all credit counts=4, in_pop_o=0, err_uturn_o=0.
- Basic grant: MY=(1,1); S input flit 0x8000_00AB (dest 2,0 → E); E_turn_i=5'b01000 → in_pop_o=5'b01000 same cycle; next cycle out_valid_o[E]=1, out_flit_o[E]=0x8000_00AB, credit[E]=3.
- Turn mismatch: same flit, E_turn_i=5'b00001 for 3 cycles → no pop, no output; E_turn_i→01000 → pop, output next cycle.
- Credit exhaustion: 5 E-bound flits from S, no credit_ret → 4 grants, 5th held.
  - credit_ret_i[E] pulse → 5th granted next cycle.
  - credit=1 with grant and return in same cycle → stays 1.
- Parallel outputs: N input dest (1,2) with S_turn=10000, and W input dest (3,1) with E_turn=00010 → in_pop_o=5'b10010; next cycle out_valid_o=5'b01100.
- U-turn plus reset: E input dest (2,1) → in_pop_o[E]=1, next cycle err_uturn_o[E]=1, credit[E] unchanged.
  - Assert rst the cycle after a grant → out_valid_o=0 that cycle, credits=4.
